ibex_lsu_data_agent: RTL and testbench
======================================

Name: ibex_lsu_data_agent

Overview:
Data-side memory agent that issues load/store transactions from ID/EX onto the data bus. It is the producer of the LSU response signals consumed by the writeback stage: response valid, error, load write enable and load write data. It supports byte, half and word accesses with sign or zero extension. Misaligned accesses are split into two bus transactions, and at most one bus transaction is outstanding at a time.

Parameters:
SplitMisaligned, 1, 1: split misaligned accesses into two bus transactions; 0: flag misaligned accesses as an error with no bus access.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
lsu_req_i  in  1  new access request from ID/EX
lsu_we_i  in  1  1 = store, 0 = load
lsu_type_i  in  2  00 word, 01 half, 10 byte (11 is treated as word)
lsu_sign_ext_i  in  1  sign-extend load data
lsu_addr_i  in  32  byte address
lsu_wdata_i  in  32  store data, right-aligned
lsu_req_accept_o  out  1  request captured this cycle
busy_o  out  1  FSM not IDLE
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_addr_o  out  32  word-aligned bus address
data_we_o  out  1  bus write
data_be_o  out  4  byte enables
data_wdata_o  out  32  bus write data
data_rvalid_i  in  1  bus response
data_err_i  in  1  bus error, qualified by rvalid
data_rdata_i  in  32  bus read data
lsu_resp_valid_o  out  1  final response pulse, one per access
lsu_resp_err_o  out  1  access failed, qualified by lsu_resp_valid_o
rf_we_lsu_o  out  1  load result write enable
rf_wdata_lsu_o  out  32  extended load data

Behaviour:
- Clock and reset: single clock clk_i; synchronous active-high reset rst_i.
- Reset:
  - FSM returns to IDLE and all registers clear.
  - All outputs are 0.
  - Reset asserted mid-access drops the transaction immediately: no response pulse; data_req_o is 0 the next cycle.
- FSM states: IDLE, GNT1, RV1, GNT2, RV2.
- Request capture:
  - lsu_req_accept_o = lsu_req_i & IDLE.
  - On accept, addr, type, we, sign_ext and wdata are registered, and a split flag is set when (word & addr[1:0]!=0) or (half & addr[1:0]==3).
  - Next state is GNT1.
  - lsu_req_i is ignored outside IDLE, including the cycle in which the final rvalid arrives.
- Bus request rules:
  - data_req_o=1 in GNT1 and GNT2.
  - addr/be/we/wdata stay stable until data_gnt_i.
  - GNT1 -> RV1 on gnt. GNT2 -> RV2 on gnt.
  - RV1 on rvalid: goes to GNT2 if split, else IDLE.
  - RV2 on rvalid -> IDLE.
  - rvalid never coincides with its own gnt.
- Bus encoding (o = addr[1:0]):
  - Phase 1: data_addr_o = {addr[31:2],2'b00}.
  - Phase 2: data_addr_o = phase-1 address + 4.
  - data_be_o phase 1 = base<<o, truncated to 4 bits. Base is 1111 for word, 0011 for half, 0001 for byte.
  - data_be_o phase 2 = (base<<o)>>4.
  - data_wdata_o = lsu_wdata rotated left by 8*o, in both phases.
- Load data:
  - Phase-1 rdata is held in rdata_q.
  - Combined value = ({rdata_i,rdata_q} >> 8*o)[31:0] when split, else (rdata_i >> 8*o).
  - The combined value is then zero- or sign-extended from 8 or 16 bits per type.
- Response (combinational from the final rvalid, i.e. RV1 non-split or RV2):
  - lsu_resp_valid_o = 1 for that cycle only.
  - lsu_resp_err_o = data_err_i | err_q, where err_q is the sticky phase-1 error.
  - rf_we_lsu_o = resp_valid & ~we & ~lsu_resp_err_o.
  - rf_wdata_lsu_o = extended data while rf_we_lsu_o is set, else 0.
- Phase-1 error on a split access: the second phase is still issued, and the error is reported at the final response.
- SplitMisaligned=0 with a misaligned request: accepted, no bus access, and the next cycle gives lsu_resp_valid_o=1, lsu_resp_err_o=1.
- Latency, aligned access with immediate gnt: accept at c0, data_req_o at c1, rvalid at c2 gives the response at c2.

Test Plan:
- Aligned LW at 0x1000, gnt in the first request cycle, rdata=0xDEADBEEF the next cycle -> data_be_o=1111; one-cycle resp_valid; rf_we_lsu_o=1; rf_wdata_lsu_o=0xDEADBEEF.
- LH signed at 0x2001, rdata=0x12F0AB34 -> data_be_o=0110; rf_wdata_lsu_o=0xFFFFF0AB. Same access unsigned -> 0x0000F0AB.
- Misaligned LW at 0x1002, phase 1 rdata=0xAABBCCDD, phase 2 rdata=0x11223344:
  - Phase 1: addr 0x1000, be 1100.
  - Phase 2: addr 0x1004, be 0011.
  - Result 0x3344AABB.
  - Exactly one resp_valid pulse.
- SB at 0x3003, wdata=0x000000A5, gnt delayed 3 cycles -> data_req_o, addr 0x3000, be 1000 and wdata 0xA5000000 held stable for 3 cycles; resp_valid=1, rf_we_lsu_o=0.
- Split LW at 0x4003 with data_err_i on phase 1 -> phase 2 still issued at 0x4004; final resp_err=1; rf_we_lsu_o=0.
- rst_i asserted in RV1 -> next cycle IDLE, data_req_o=0, no resp_valid; a new request at 0x1000 is then accepted normally.

Source files
------------

// File: rtl/ibex_lsu_data_agent.sv
// ibex_lsu_data_agent: issues LSU loads/stores on the data bus, splitting misaligned
// accesses into two transactions, and produces the writeback response.
module ibex_lsu_data_agent #(
   parameter bit SplitMisaligned = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [1:0]  lsu_type_i,
   input  logic        lsu_sign_ext_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   output logic        lsu_req_accept_o,
   output logic        busy_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic        data_err_i,
   input  logic [31:0] data_rdata_i,
   output logic        lsu_resp_valid_o,
   output logic        lsu_resp_err_o,
   output logic        rf_we_lsu_o,
   output logic [31:0] rf_wdata_lsu_o
);
   typedef enum logic [2:0] {IDLE, GNT1, RV1, GNT2, RV2} state_e;
   state_e state_q, state_d;
   logic [31:0] addr_q, wdata_q, rdata_q, comb, ext;
   logic [1:0]  type_q;
   logic        we_q, sext_q, split_q, mis_q, err_q;
   logic        split_new, p2, req, fin;
   logic [4:0]  sh;
   logic [3:0]  base;
   logic [7:0]  be_full;

   assign split_new = (lsu_type_i == 2'b00 || lsu_type_i == 2'b11) ? lsu_addr_i[1:0] != 2'b00 :
                      lsu_type_i == 2'b01 && lsu_addr_i[1:0] == 2'b11;
   assign lsu_req_accept_o = lsu_req_i && state_q == IDLE && !rst_i;
   assign busy_o = state_q != IDLE && !rst_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (lsu_req_i) state_d = (split_new && !SplitMisaligned) ? RV1 : GNT1;
         GNT1: if (data_gnt_i) state_d = RV1;
         RV1:  if (mis_q) state_d = IDLE;
               else if (data_rvalid_i) state_d = split_q ? GNT2 : IDLE;
         GNT2: if (data_gnt_i) state_d = RV2;
         RV2:  if (data_rvalid_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         type_q  <= '0;
         we_q    <= 1'b0;
         sext_q  <= 1'b0;
         split_q <= 1'b0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (lsu_req_accept_o) begin
            addr_q  <= lsu_addr_i;
            wdata_q <= lsu_wdata_i;
            type_q  <= lsu_type_i;
            we_q    <= lsu_we_i;
            sext_q  <= lsu_sign_ext_i;
            split_q <= split_new;
            mis_q   <= split_new && !SplitMisaligned;
            err_q   <= 1'b0;
         end
         if (state_q == RV1 && data_rvalid_i) begin
            rdata_q <= data_rdata_i;
            err_q   <= data_err_i;
         end
      end
   end

   assign sh      = {addr_q[1:0], 3'b000};
   assign base    = type_q == 2'b01 ? 4'b0011 : type_q == 2'b10 ? 4'b0001 : 4'b1111;
   assign be_full = {4'b0000, base} << addr_q[1:0];
   assign p2      = state_q == GNT2;
   assign req     = (state_q == GNT1 || p2) && !rst_i;

   assign data_req_o   = req;
   assign data_we_o    = req && we_q;
   assign data_addr_o  = req ? {addr_q[31:2], 2'b00} + (p2 ? 32'd4 : 32'd0) : 32'd0;
   assign data_be_o    = req ? (p2 ? be_full[7:4] : be_full[3:0]) : 4'b0000;
   assign data_wdata_o = req ? (wdata_q << sh) | (wdata_q >> (6'd32 - {1'b0, sh})) : 32'd0;

   // Split loads stitch the phase-1 word below the phase-2 word before shifting down.
   assign comb = split_q ? 32'({data_rdata_i, rdata_q} >> sh) : data_rdata_i >> sh;
   assign ext  = type_q == 2'b10 ? {{24{sext_q & comb[7]}}, comb[7:0]} :
                 type_q == 2'b01 ? {{16{sext_q & comb[15]}}, comb[15:0]} : comb;

   assign fin = !rst_i && ((state_q == RV1 && (mis_q || (data_rvalid_i && !split_q))) ||
                           (state_q == RV2 && data_rvalid_i));
   assign lsu_resp_valid_o = fin;
   assign lsu_resp_err_o   = fin && (mis_q || data_err_i || err_q);
   assign rf_we_lsu_o      = fin && !we_q && !lsu_resp_err_o;
   assign rf_wdata_lsu_o   = rf_we_lsu_o ? ext : 32'd0;
endmodule

// File: tb/tb_ibex_lsu_data_agent.sv
// tb_ibex_lsu_data_agent: directed checks of the LSU data agent, split and
// error-on-misaligned variants.
module tb_ibex_lsu_data_agent;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req = 1'b0, req2 = 1'b0, we = 1'b0, sext = 1'b0;
   logic [1:0]  typ = 2'b00;
   logic [31:0] addr = '0, wdata = '0, rdata = '0;
   logic        gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
   logic        acc, busy, dreq, dwe, rv, rerr, rfwe;
   logic [31:0] daddr, dwdata, rfwd;
   logic [3:0]  dbe;
   logic        acc2, busy2, dreq2, dwe2, rv2, rerr2, rfwe2;
   logic [31:0] daddr2, dwdata2, rfwd2;
   logic [3:0]  dbe2;
   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   ibex_lsu_data_agent #(.SplitMisaligned(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .lsu_req_i(req), .lsu_we_i(we), .lsu_type_i(typ),
      .lsu_sign_ext_i(sext), .lsu_addr_i(addr), .lsu_wdata_i(wdata),
      .lsu_req_accept_o(acc), .busy_o(busy), .data_req_o(dreq), .data_gnt_i(gnt),
      .data_addr_o(daddr), .data_we_o(dwe), .data_be_o(dbe), .data_wdata_o(dwdata),
      .data_rvalid_i(rvalid), .data_err_i(err), .data_rdata_i(rdata),
      .lsu_resp_valid_o(rv), .lsu_resp_err_o(rerr), .rf_we_lsu_o(rfwe), .rf_wdata_lsu_o(rfwd));

   ibex_lsu_data_agent #(.SplitMisaligned(1'b0)) dut2 (
      .clk_i(clk), .rst_i(rst), .lsu_req_i(req2), .lsu_we_i(we), .lsu_type_i(typ),
      .lsu_sign_ext_i(sext), .lsu_addr_i(addr), .lsu_wdata_i(wdata),
      .lsu_req_accept_o(acc2), .busy_o(busy2), .data_req_o(dreq2), .data_gnt_i(gnt),
      .data_addr_o(daddr2), .data_we_o(dwe2), .data_be_o(dbe2), .data_wdata_o(dwdata2),
      .data_rvalid_i(rvalid), .data_err_i(err), .data_rdata_i(rdata),
      .lsu_resp_valid_o(rv2), .lsu_resp_err_o(rerr2), .rf_we_lsu_o(rfwe2), .rf_wdata_lsu_o(rfwd2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input string tag, input logic w, input logic [1:0] t, input logic s,
                        input logic [31:0] a, input logic [31:0] wd);
      we = w; typ = t; sext = s; addr = a; wdata = wd; req = 1'b1;
      @(negedge clk);
      chk({tag, "_accept"}, 32'(acc), 32'd1);
      nxt;
      req = 1'b0;
   endtask

   // Holds the request dly cycles without grant, grants, then presents rvalid and stops at its negedge.
   task automatic phase(input string tag, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic w, input int dly,
                        input logic [31:0] rd, input logic e);
      for (int i = 0; i <= dly; i++) begin
         gnt = (i == dly);
         @(negedge clk);
         chk({tag, "_req"}, 32'(dreq), 32'd1);
         chk({tag, "_addr"}, daddr, a);
         chk({tag, "_be"}, 32'(dbe), 32'(be));
         chk({tag, "_wdata"}, dwdata, wd);
         chk({tag, "_we"}, 32'(dwe), 32'(w));
         nxt;
      end
      gnt = 1'b0; rvalid = 1'b1; rdata = rd; err = e;
      @(negedge clk);
   endtask

   task automatic done;
      nxt;
      rvalid = 1'b0; err = 1'b0; rdata = '0;
   endtask

   task automatic resp(input string tag, input logic v, input logic e, input logic rw,
                       input logic [31:0] d);
      chk({tag, "_rvalid"}, 32'(rv), 32'(v));
      chk({tag, "_rerr"}, 32'(rerr), 32'(e));
      chk({tag, "_rfwe"}, 32'(rfwe), 32'(rw));
      chk({tag, "_rfwd"}, rfwd, d);
   endtask

   initial begin
      nxt; nxt;
      @(negedge clk);
      chk("rst_req", 32'(dreq), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      resp("rst", 1'b0, 1'b0, 1'b0, 32'd0);
      nxt;
      rst = 1'b0;

      issue("lw", 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0);
      phase("lw", 32'h1000, 4'b1111, 32'h0, 1'b0, 0, 32'hDEADBEEF, 1'b0);
      resp("lw", 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
      done;
      @(negedge clk);
      chk("lw_pulse", 32'(rv), 32'd0);
      chk("lw_idle", 32'(busy), 32'd0);
      nxt;

      issue("lhs", 1'b0, 2'b01, 1'b1, 32'h2001, 32'h0);
      phase("lhs", 32'h2000, 4'b0110, 32'h0, 1'b0, 0, 32'h12F0AB34, 1'b0);
      resp("lhs", 1'b1, 1'b0, 1'b1, 32'hFFFFF0AB);
      done;

      issue("lhu", 1'b0, 2'b01, 1'b0, 32'h2001, 32'h0);
      req = 1'b1;
      phase("lhu", 32'h2000, 4'b0110, 32'h0, 1'b0, 0, 32'h12F0AB34, 1'b0);
      chk("lhu_busy_ignore", 32'(acc), 32'd0);
      resp("lhu", 1'b1, 1'b0, 1'b1, 32'h0000F0AB);
      req = 1'b0;
      done;

      issue("mlw", 1'b0, 2'b00, 1'b0, 32'h1002, 32'h0);
      phase("mlw1", 32'h1000, 4'b1100, 32'h0, 1'b0, 0, 32'hAABBCCDD, 1'b0);
      resp("mlw1", 1'b0, 1'b0, 1'b0, 32'd0);
      done;
      phase("mlw2", 32'h1004, 4'b0011, 32'h0, 1'b0, 1, 32'h11223344, 1'b0);
      resp("mlw2", 1'b1, 1'b0, 1'b1, 32'h3344AABB);
      done;
      @(negedge clk);
      chk("mlw_pulse", 32'(rv), 32'd0);
      nxt;

      issue("sb", 1'b1, 2'b10, 1'b0, 32'h3003, 32'h000000A5);
      phase("sb", 32'h3000, 4'b1000, 32'hA5000000, 1'b1, 3, 32'h0, 1'b0);
      resp("sb", 1'b1, 1'b0, 1'b0, 32'd0);
      done;

      issue("elw", 1'b0, 2'b00, 1'b0, 32'h4003, 32'h0);
      phase("elw1", 32'h4000, 4'b1000, 32'h0, 1'b0, 0, 32'h0, 1'b1);
      resp("elw1", 1'b0, 1'b0, 1'b0, 32'd0);
      done;
      phase("elw2", 32'h4004, 4'b0111, 32'h0, 1'b0, 0, 32'h55667788, 1'b0);
      resp("elw2", 1'b1, 1'b1, 1'b0, 32'd0);
      done;

      issue("rlw", 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0);
      gnt = 1'b1;
      @(negedge clk);
      chk("rlw_req", 32'(dreq), 32'd1);
      nxt;
      gnt = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("rlw_rst_rv", 32'(rv), 32'd0);
      nxt;
      rst = 1'b0;
      @(negedge clk);
      chk("rlw_idle", 32'(busy), 32'd0);
      chk("rlw_noreq", 32'(dreq), 32'd0);
      chk("rlw_no_resp", 32'(rv), 32'd0);
      nxt;
      issue("rlw2", 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0);
      phase("rlw2", 32'h1000, 4'b1111, 32'h0, 1'b0, 0, 32'h5A5A1234, 1'b0);
      resp("rlw2", 1'b1, 1'b0, 1'b1, 32'h5A5A1234);
      done;

      we = 1'b0; typ = 2'b00; addr = 32'h1002; req2 = 1'b1;
      @(negedge clk);
      chk("nos_accept", 32'(acc2), 32'd1);
      nxt;
      req2 = 1'b0;
      @(negedge clk);
      chk("nos_rvalid", 32'(rv2), 32'd1);
      chk("nos_rerr", 32'(rerr2), 32'd1);
      chk("nos_rfwe", 32'(rfwe2), 32'd0);
      chk("nos_noreq", 32'(dreq2), 32'd0);
      nxt;
      @(negedge clk);
      chk("nos_pulse", 32'(rv2), 32'd0);
      chk("nos_idle", 32'(busy2), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
